// File: rtl/rc4_pkg.sv
// Shared RC4 types: byte alias and the PRGA controller state encoding,
// reused by the init/KSA/PRGA stages.
package rc4_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_RD,
      ST_LEN_GET,
      ST_RD_I,
      ST_GET_I,
      ST_GET_J,
      ST_WR_J,
      ST_RD_PAD,
      ST_GET_PAD,
      ST_DONE
   } prga_state_t;

endpackage

// File: rtl/prga_decrypt.sv
// RC4 PRGA decrypt engine: walks the KSA-prepared S-box, generates one pad byte
// per ciphertext byte and writes pt[0]=L followed by pt[1..L].
module prga_decrypt
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] s_addr,
   input  logic [7:0] s_rddata,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   output logic [7:0] ct_addr,
   input  logic [7:0] ct_rddata,
   output logic [7:0] pt_addr,
   output logic [7:0] pt_wrdata,
   output logic       pt_wren
);

   prga_state_t state_reg, state_next;
   byte_t       i_reg, i_next;
   byte_t       j_reg, j_next;
   byte_t       k_reg, k_next;
   byte_t       len_reg, len_next;
   byte_t       si_reg, si_next;
   byte_t       sj_reg, sj_next;
   byte_t       ct_reg, ct_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         i_reg     <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
         len_reg   <= '0;
         si_reg    <= '0;
         sj_reg    <= '0;
         ct_reg    <= '0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         k_reg     <= k_next;
         len_reg   <= len_next;
         si_reg    <= si_next;
         sj_reg    <= sj_next;
         ct_reg    <= ct_next;
      end
   end

   // All memory ports are driven only from the current state, so leaving a
   // state (including via reset) silences every write enable immediately.
   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      j_next     = j_reg;
      k_next     = k_reg;
      len_next   = len_reg;
      si_next    = si_reg;
      sj_next    = sj_reg;
      ct_next    = ct_reg;
      rdy        = 1'b0;
      s_addr     = '0;
      s_wrdata   = '0;
      s_wren     = 1'b0;
      ct_addr    = '0;
      pt_addr    = '0;
      pt_wrdata  = '0;
      pt_wren    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en) begin
               i_next     = '0;
               j_next     = '0;
               k_next     = '0;
               state_next = ST_LEN_RD;
            end
         end
         ST_LEN_RD: begin
            ct_addr    = 8'd0;
            state_next = ST_LEN_GET;
         end
         ST_LEN_GET: begin
            len_next   = ct_rddata;
            pt_addr    = 8'd0;
            pt_wrdata  = ct_rddata;
            pt_wren    = 1'b1;
            k_next     = 8'd1;
            state_next = (ct_rddata != 8'd0) ? ST_RD_I : ST_DONE;
         end
         ST_RD_I: begin
            s_addr     = i_reg + 8'd1;
            ct_addr    = k_reg;
            i_next     = i_reg + 8'd1;
            state_next = ST_GET_I;
         end
         ST_GET_I: begin
            si_next    = s_rddata;
            ct_next    = ct_rddata;
            j_next     = j_reg + s_rddata;
            s_addr     = j_reg + s_rddata;
            state_next = ST_GET_J;
         end
         ST_GET_J: begin
            // When i==j both writes carry the same value, leaving S intact.
            sj_next    = s_rddata;
            s_addr     = i_reg;
            s_wrdata   = s_rddata;
            s_wren     = 1'b1;
            state_next = ST_WR_J;
         end
         ST_WR_J: begin
            s_addr     = j_reg;
            s_wrdata   = si_reg;
            s_wren     = 1'b1;
            state_next = ST_RD_PAD;
         end
         ST_RD_PAD: begin
            s_addr     = si_reg + sj_reg;
            state_next = ST_GET_PAD;
         end
         ST_GET_PAD: begin
            pt_addr   = k_reg;
            pt_wrdata = s_rddata ^ ct_reg;
            pt_wren   = 1'b1;
            // Compare before incrementing so L=255 never wraps k.
            if (k_reg == len_reg) begin
               state_next = ST_DONE;
            end else begin
               k_next     = k_reg + 8'd1;
               state_next = ST_RD_I;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: behavioural memories, plain RC4 reference model and
// a scoreboard of expected plaintext writes.
module tb_prga_decrypt;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       rdy;
   logic [7:0] s_addr, s_rddata, s_wrdata;
   logic       s_wren;
   logic [7:0] ct_addr, ct_rddata;
   logic [7:0] pt_addr, pt_wrdata;
   logic       pt_wren;

   logic [7:0] s_mem  [256];
   logic [7:0] ct_mem [256];
   logic [7:0] pt_mem [256];
   int         model_s[256];
   logic [15:0] exp_q[$];

   int checks = 0;
   int errors = 0;

   prga_decrypt dut (
      .clk(clk), .rst(rst), .en(en), .rdy(rdy),
      .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
      .ct_addr(ct_addr), .ct_rddata(ct_rddata),
      .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
   );

   always #5 clk = ~clk;

   // Synchronous memories with one-cycle read latency (old data on collision).
   always @(posedge clk) begin
      s_rddata  <= s_mem[s_addr];
      ct_rddata <= ct_mem[ct_addr];
      if (s_wren)  s_mem[s_addr]   = s_wrdata;
      if (pt_wren) pt_mem[pt_addr] = pt_wrdata;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every plaintext write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_wren && pt_wren) check("wren_exclusive", 1, 0);
         if (pt_wren) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pt_wr_unexpected: got addr 0x%0h data 0x%0h expected no write",
                        pt_addr, pt_wrdata);
            end else begin
               check("pt_wr", {pt_addr, pt_wrdata}, exp_q.pop_front());
            end
         end
      end
   end

   // Plain RC4 PRGA over model_s; pushes every expected plaintext write.
   task automatic ref_run();
      int len, ii, jj, t, pad;
      len = ct_mem[0];
      exp_q.push_back({8'd0, ct_mem[0]});
      ii = 0;
      jj = 0;
      for (int k = 1; k <= len; k++) begin
         ii = (ii + 1) % 256;
         jj = (jj + model_s[ii]) % 256;
         t = model_s[ii]; model_s[ii] = model_s[jj]; model_s[jj] = t;
         pad = model_s[(model_s[ii] + model_s[jj]) % 256];
         exp_q.push_back({8'(k), 8'(pad) ^ ct_mem[k]});
      end
   endtask

   task automatic load_s(input int a[256]);
      for (int x = 0; x < 256; x++) begin
         s_mem[x]   = 8'(a[x]);
         model_s[x] = a[x];
      end
   endtask

   task automatic load_identity();
      int a[256];
      for (int x = 0; x < 256; x++) a[x] = x;
      load_s(a);
   endtask

   task automatic load_random_perm();
      int a[256];
      int r, t;
      for (int x = 0; x < 256; x++) a[x] = x;
      for (int x = 255; x > 0; x--) begin
         r = $urandom_range(x, 0);
         t = a[x]; a[x] = a[r]; a[r] = t;
      end
      load_s(a);
   endtask

   task automatic load_ksa(input logic [23:0] key);
      int a[256];
      int jj, t, kb;
      for (int x = 0; x < 256; x++) a[x] = x;
      jj = 0;
      for (int x = 0; x < 256; x++) begin
         kb = (x % 3 == 0) ? key[23:16] : (x % 3 == 1) ? key[15:8] : key[7:0];
         jj = (jj + a[x] + kb) % 256;
         t = a[x]; a[x] = a[jj]; a[jj] = t;
      end
      load_s(a);
   endtask

   task automatic check_s_final(input string name);
      int mism = 0;
      for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(model_s[x])) mism++;
      check(name, mism, 0);
   endtask

   // Counts from the accept cycle (cyc=1 is the first busy cycle) until rdy.
   task automatic wait_idle(input int start, output int cyc, output int swr);
      cyc = start;
      swr = 0;
      while (!rdy && cyc < 4000) begin
         @(negedge clk);
         en = 1'b0;
         cyc++;
         if (s_wren) swr++;
      end
   endtask

   task automatic run_msg(input string name);
      int cyc, swr, len;
      len = ct_mem[0];
      ref_run();
      @(negedge clk);
      check({name, "_rdy_idle"}, rdy, 1);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      wait_idle(1, cyc, swr);
      check({name, "_latency"}, cyc, 4 + 6 * len);
      check({name, "_s_wren_pulses"}, swr, 2 * len);
      check({name, "_pt_left"}, exp_q.size(), 0);
      check_s_final({name, "_s_final"});
   endtask

   initial begin
      int    cyc, swr, n;
      string msg;
      int    ks[256];
      int    ii, jj, t, pad;

      for (int x = 0; x < 256; x++) begin
         ct_mem[x] = 8'd0;
         pt_mem[x] = 8'd0;
      end
      load_identity();
      rst = 1'b1;
      en  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rdy", rdy, 1);
      check("reset_wren", {s_wren, pt_wren}, 0);
      check("reset_addr", {s_addr, ct_addr, pt_addr}, 0);
      check("reset_wrdata", {s_wrdata, pt_wrdata}, 0);
      rst = 1'b0;

      // Single zero byte on identity S.
      ct_mem[0] = 8'd1; ct_mem[1] = 8'h00;
      run_msg("one_byte");
      check("one_byte_pt0", pt_mem[0], 8'h01);
      check("one_byte_pt1", pt_mem[1], 8'h02);

      // Two bytes on identity S.
      load_identity();
      ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42;
      run_msg("two_byte");
      check("two_byte_pt1", pt_mem[1], 8'h43);
      check("two_byte_pt2", pt_mem[2], 8'h47);
      check("two_byte_s2s3", {s_mem[2], s_mem[3]}, 16'h0302);

      // Empty message.
      ct_mem[0] = 8'd0;
      run_msg("empty");
      check("empty_pt0", pt_mem[0], 8'h00);

      // KSA-prepared S with key 00033C decrypts a known ASCII string.
      load_ksa(24'h00033C);
      msg = "Hello from RC4!";
      for (int x = 0; x < 256; x++) ks[x] = model_s[x];
      ii = 0; jj = 0;
      ct_mem[0] = 8'(msg.len());
      for (int k = 1; k <= msg.len(); k++) begin
         ii = (ii + 1) % 256;
         jj = (jj + ks[ii]) % 256;
         t = ks[ii]; ks[ii] = ks[jj]; ks[jj] = t;
         pad = ks[(ks[ii] + ks[jj]) % 256];
         ct_mem[k] = 8'(pad) ^ msg[k-1];
      end
      run_msg("ksa_vec");
      n = 0;
      for (int k = 1; k <= msg.len(); k++) if (pt_mem[k] !== msg[k-1]) n++;
      check("ksa_vec_ascii", n, 0);

      // Randomised messages on random permutations, ending with L=255.
      for (int r = 0; r < 6; r++) begin
         load_random_perm();
         ct_mem[0] = (r == 5) ? 8'd255 : 8'($urandom_range(40, 1));
         for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom);
         run_msg($sformatf("rand%0d", r));
      end

      // Reset during GET_J of the third byte of a long message.
      load_random_perm();
      ct_mem[0] = 8'd200;
      for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom);
      ref_run();
      @(negedge clk);
      en = 1'b1;
      n = 0;
      cyc = 0;
      while (n < 5 && cyc < 100) begin
         @(negedge clk);
         en = 1'b0;
         cyc++;
         if (s_wren) n++;
      end
      check("midrst_reached_getj", n, 5);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("midrst_rdy", rdy, 1);
      check("midrst_wren", {s_wren, pt_wren}, 0);
      check("midrst_addr", {s_addr, ct_addr, pt_addr}, 0);
      rst = 1'b0;
      swr = 0;
      n = 0;
      repeat (40) begin
         @(negedge clk);
         if (s_wren) swr++;
         if (!rdy) n++;
      end
      check("midrst_no_s_wren", swr, 0);
      check("midrst_stays_idle", n, 0);

      // en held high across completion: second run restarts with i=j=0.
      load_identity();
      ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h42;
      ref_run();
      ref_run();
      @(negedge clk);
      en = 1'b1;
      cyc = 0;
      while (!rdy || cyc == 0) begin
         @(negedge clk);
         cyc++;
         if (cyc >= 4000) break;
      end
      check("hold_first_latency", cyc, 16);
      @(negedge clk);
      check("hold_restart_busy", rdy, 0);
      en = 1'b0;
      wait_idle(1, cyc, swr);
      check("hold_second_latency", cyc, 16);
      check("hold_pt_left", exp_q.size(), 0);
      check("hold_pt2", pt_mem[2], 8'h45);
      check_s_final("hold_s_final");

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter: none; all widths fixed (8-bit address, 8-bit data, 256-entry memories).
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 en  input  1  start request, sampled only while rdy=1.
REQ-005 rdy  output  1  high = idle and able to accept en.
REQ-006 s_addr  output  8  S-box memory address (RC4 state array produced by init+KSA).
REQ-007 s_rddata  input  8  S-box read data, valid the cycle after s_addr is presented.
REQ-008 s_wrdata  output  8  S-box write data.
REQ-009 s_wren  output  1  S-box write enable.
REQ-010 ct_addr  output  8  ciphertext memory address; ct[0]=length L, ct[1..L]=bytes.
REQ-011 ct_rddata  input  8  ciphertext read data, one-cycle read latency.
REQ-012 pt_addr  output  8  plaintext memory address.
REQ-013 pt_wrdata  output  8  plaintext write data.
REQ-014 pt_wren  output  1  plaintext write enable.

Function
REQ-015 Block SHALL run the RC4 PRGA on the S-box left by KSA: for k=1..L: i=i+1, j=j+s[i], swap s[i]/s[j], pad=s[s[i]+s[j]], pt[k]=pad XOR ct[k]; all sums mod 256.
REQ-016 i and j SHALL be 8-bit registers cleared to 0 at each accepted start.
REQ-017 Handshake: en high on a cycle with rdy=1 SHALL start; rdy SHALL drop the next cycle; en while rdy=0 SHALL be ignored.
REQ-018 States: IDLE, LEN_RD, LEN_GET, RD_I, GET_I, GET_J, WR_J, RD_PAD, GET_PAD, DONE.
REQ-019 LEN_RD: ct_addr=0. LEN_GET: latch L, write pt[0]=L, k=1; go RD_I if L>0 else DONE.
REQ-020 RD_I: s_addr=i+1, ct_addr=k, update i. GET_I: latch s[i] and ct[k], j=j+s[i], s_addr=new j.
REQ-021 GET_J: latch s[j], write s[i]=s[j]. WR_J: write s[j]=old s[i].
REQ-022 RD_PAD: s_addr=s[i]+s[j] (8-bit wrap). GET_PAD: pt_addr=k, pt_wrdata=s_rddata XOR ct[k], pt_wren=1; k==L -> DONE else k=k+1, RD_I.
REQ-023 DONE SHALL go to IDLE next cycle; rdy=1 in IDLE only.
REQ-024 Latency: rdy SHALL reassert exactly 4+6L cycles after the accept edge.
REQ-025 i==j SHALL be handled: two writes of same value, s unchanged.
REQ-026 s_wren and pt_wren SHALL never both be high; each write enable high for exactly one cycle per write.
REQ-027 L=255 SHALL complete without k overflow (k compare before increment).

Reset
REQ-028 rst SHALL force IDLE, rdy=1, i=j=k=0, all wren=0, all addresses/wrdata=0 on next edge.
REQ-029 rst mid-operation SHALL abort with no further memory writes; partial pt/S contents left as-is.

Structure
REQ-030 Shared package rc4_pkg SHALL hold the state enum and the byte typedef, reused by init/KSA stages.
REQ-031 No sub-module is natural; single FSM plus datapath registers in one module.

Verification
REQ-032 Identity S (s[x]=x), ct={1,0x00}, pulse en -> pt[0]=0x01, pt[1]=0x02, S unchanged, rdy back after 10 cycles.
REQ-033 Identity S, ct={2,0x41,0x42} -> pt={0x02,0x43,0x47}, s[2]=3, s[3]=2, rdy after 16 cycles.
REQ-034 ct={0}, en -> pt[0]=0x00, zero s_wren pulses, rdy after 4 cycles.
REQ-035 rst asserted in GET_J during long message -> next cycle IDLE, rdy=1, no further s_wren/pt_wren.
REQ-036 S from KSA with key 24'h00033C, ct=known test vector -> pt matches expected ASCII string byte-exact.
REQ-037 en held high across completion -> second run starts only after rdy=1, with i=j=0.
